// File: rtl/transfer_sequencer.sv
// Sequences one register-to-register move or immediate load over a shared transfer bus:
// drive the source, strobe the destination load, then hold the bus stable while it latches.
module transfer_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_kind,
    input  logic [1:0] i_cmd_src,
    input  logic [1:0] i_cmd_dst,
    input  logic [7:0] i_cmd_imm,
    output logic       o_cmd_ready,
    output logic [3:0] o_assert_transfer,
    output logic [3:0] o_load_transfer,
    output logic       o_imm_drive,
    output logic [7:0] o_imm,
    output logic       o_done,
    output logic [7:0] o_move_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LOAD,
        LATCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;
    logic       kind_q, kind_d;
    logic [1:0] src_q, src_d;
    logic [1:0] dst_q, dst_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] move_count_q, move_count_d;

    logic       self_move;
    logic       source_active;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
            kind_q       <= 1'b0;
            src_q        <= 2'd0;
            dst_q        <= 2'd0;
            imm_q        <= 8'd0;
            move_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            kind_q       <= kind_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            imm_q        <= imm_d;
            move_count_q <= move_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        kind_d       = kind_q;
        src_d        = src_q;
        dst_d        = dst_q;
        imm_d        = imm_q;
        move_count_d = move_count_q;

        unique case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    kind_d       = i_cmd_kind;
                    src_d        = i_cmd_src;
                    dst_d        = i_cmd_dst;
                    imm_d        = i_cmd_imm;
                    settle_cnt_d = 4'(SETTLE_CYCLES - 1);
                    // A move onto itself needs no bus traffic, only the completion pulse.
                    if (!i_cmd_kind && (i_cmd_src == i_cmd_dst)) begin
                        state_d = LATCH;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            LOAD: begin
                state_d = LATCH;
            end
            LATCH: begin
                state_d      = IDLE;
                move_count_d = move_count_q + 8'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The source keeps driving through LATCH so the destination samples a settled bus.
    always_comb begin
        self_move         = !kind_q && (src_q == dst_q);
        source_active     = (state_q != IDLE) && !self_move;
        o_cmd_ready       = (state_q == IDLE);
        o_done            = (state_q == LATCH);
        o_imm_drive       = source_active && kind_q;
        o_imm             = o_imm_drive ? imm_q : 8'd0;
        o_assert_transfer = (source_active && !kind_q) ? (4'b0001 << src_q) : 4'b0000;
        o_load_transfer   = (state_q == LOAD) ? (4'b0001 << dst_q) : 4'b0000;
        o_move_count      = move_count_q;
    end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed self-checking bench: one sequencer with SETTLE_CYCLES=1 and one with 3,
// sharing clock, reset and command fields but with separate valid strobes.
module tb_transfer_sequencer;

    logic       clk;
    logic       reset;
    logic       valid1, valid3;
    logic       kind;
    logic [1:0] src, dst;
    logic [7:0] imm;

    logic       ready1, imm_drive1, done1;
    logic [3:0] assert1, load1;
    logic [7:0] imm_out1, count1;
    logic       ready3, imm_drive3, done3;
    logic [3:0] assert3, load3;
    logic [7:0] imm_out3, count3;

    int tests_run = 0;
    int tests_failed = 0;
    logic prev_done1 = 1'b0;
    logic prev_done3 = 1'b0;

    transfer_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_cmd_valid(valid1), .i_cmd_kind(kind),
        .i_cmd_src(src), .i_cmd_dst(dst), .i_cmd_imm(imm), .o_cmd_ready(ready1),
        .o_assert_transfer(assert1), .o_load_transfer(load1), .o_imm_drive(imm_drive1),
        .o_imm(imm_out1), .o_done(done1), .o_move_count(count1)
    );

    transfer_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .i_clk(clk), .i_reset(reset), .i_cmd_valid(valid3), .i_cmd_kind(kind),
        .i_cmd_src(src), .i_cmd_dst(dst), .i_cmd_imm(imm), .o_cmd_ready(ready3),
        .o_assert_transfer(assert3), .o_load_transfer(load3), .o_imm_drive(imm_drive3),
        .o_imm(imm_out3), .o_done(done3), .o_move_count(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bus exclusivity and single-cycle done, sampled mid-cycle on both instances.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("bus_excl1", {31'd0, ($countones(assert1) <= 1) && !(imm_drive1 && (assert1 != 4'd0))
                                      && ($countones(load1) <= 1)}, 32'd1);
            checkOutput("bus_excl3", {31'd0, ($countones(assert3) <= 1) && !(imm_drive3 && (assert3 != 4'd0))
                                      && ($countones(load3) <= 1)}, 32'd1);
            checkOutput("done_twice1", {31'd0, done1 && prev_done1}, 32'd0);
            checkOutput("done_twice3", {31'd0, done3 && prev_done3}, 32'd0);
        end
        prev_done1 = done1;
        prev_done3 = done3;
    end

    // Waits for ready on the selected instance, then presents one command for one edge.
    task automatic applyStimulus(input bit sel3, input logic k, input logic [1:0] s,
                                 input logic [1:0] d, input logic [7:0] i);
        int waited = 0;
        while (!(sel3 ? ready3 : ready1) && waited < 20) begin
            tick();
            waited++;
        end
        if (!(sel3 ? ready3 : ready1)) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        kind = k; src = s; dst = d; imm = i;
        if (sel3) valid3 = 1'b1; else valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        valid3 = 1'b0;
    endtask

    logic       ck [3];
    logic [1:0] cs [3];
    logic [1:0] cd [3];
    logic [7:0] ci [3];

    initial begin
        int acc, phase, cycles;
        logic rdy_before;
        logic cur_kind;
        logic [1:0] cur_src, cur_dst;
        logic [7:0] cur_imm;

        reset = 1'b1; valid1 = 1'b0; valid3 = 1'b0;
        kind = 1'b0; src = 2'd0; dst = 2'd0; imm = 8'd0;
        tick(); tick();
        reset = 1'b0;

        checkOutput("rst_ready", {31'd0, ready1}, 32'd1);
        checkOutput("rst_assert", {28'd0, assert1}, 32'h0);
        checkOutput("rst_load", {28'd0, load1}, 32'h0);
        checkOutput("rst_imm", {23'd0, imm_drive1, imm_out1}, 32'h0);
        checkOutput("rst_done", {31'd0, done1}, 32'd0);
        checkOutput("rst_count", {24'd0, count1}, 32'd0);

        // Register move 1 -> 2
        applyStimulus(1'b0, 1'b0, 2'd1, 2'd2, 8'h00);
        checkOutput("mv_c1_assert", {28'd0, assert1}, 32'h2);
        checkOutput("mv_c1_load", {28'd0, load1}, 32'h0);
        checkOutput("mv_c1_ready", {31'd0, ready1}, 32'd0);
        tick();
        checkOutput("mv_c2_assert", {28'd0, assert1}, 32'h2);
        checkOutput("mv_c2_load", {28'd0, load1}, 32'h4);
        checkOutput("mv_c2_done", {31'd0, done1}, 32'd0);
        tick();
        checkOutput("mv_c3_assert", {28'd0, assert1}, 32'h2);
        checkOutput("mv_c3_load", {28'd0, load1}, 32'h0);
        checkOutput("mv_c3_done", {31'd0, done1}, 32'd1);
        tick();
        checkOutput("mv_c4_ready", {31'd0, ready1}, 32'd1);
        checkOutput("mv_c4_assert", {28'd0, assert1}, 32'h0);
        checkOutput("mv_c4_done", {31'd0, done1}, 32'd0);
        checkOutput("mv_count", {24'd0, count1}, 32'd1);

        // Immediate load 0xA5 into register 3 (src field is don't-care)
        applyStimulus(1'b0, 1'b1, 2'd2, 2'd3, 8'hA5);
        for (int c = 1; c <= 3; c++) begin
            checkOutput("imm_drive", {31'd0, imm_drive1}, 32'd1);
            checkOutput("imm_value", {24'd0, imm_out1}, 32'hA5);
            checkOutput("imm_assert", {28'd0, assert1}, 32'h0);
            checkOutput("imm_load", {28'd0, load1}, (c == 2) ? 32'h8 : 32'h0);
            checkOutput("imm_done", {31'd0, done1}, (c == 3) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("imm_idle", {23'd0, imm_drive1, imm_out1}, 32'h0);
        checkOutput("imm_count", {24'd0, count1}, 32'd2);

        // Self-move 0 -> 0
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0, 8'h55);
        checkOutput("self_done", {31'd0, done1}, 32'd1);
        checkOutput("self_strobes", {19'd0, imm_drive1, assert1, load1, imm_out1[3:0]}, 32'h0);
        tick();
        checkOutput("self_ready", {31'd0, ready1}, 32'd1);
        checkOutput("self_count", {24'd0, count1}, 32'd3);

        // Back-to-back with valid held; fields are junk while busy and must not be captured.
        ck[0] = 1'b0; cs[0] = 2'd0; cd[0] = 2'd3; ci[0] = 8'h00;
        ck[1] = 1'b1; cs[1] = 2'd0; cd[1] = 2'd1; ci[1] = 8'h3C;
        ck[2] = 1'b0; cs[2] = 2'd2; cd[2] = 2'd1; ci[2] = 8'h00;
        acc = 0; phase = 0; cycles = 0;
        cur_kind = 1'b0; cur_src = 2'd0; cur_dst = 2'd0; cur_imm = 8'd0;
        valid1 = 1'b1;
        while (acc < 3 && cycles < 40) begin
            if (ready1) begin
                kind = ck[acc]; src = cs[acc]; dst = cd[acc]; imm = ci[acc];
            end else begin
                kind = 1'b0; src = 2'd3; dst = 2'd0; imm = 8'hFF;
            end
            rdy_before = ready1;
            tick();
            cycles++;
            if (rdy_before) begin
                cur_kind = ck[acc]; cur_src = cs[acc]; cur_dst = cd[acc]; cur_imm = ci[acc];
                acc++;
                phase = 1;
            end else if (phase != 0) begin
                phase = (phase == 3) ? 0 : phase + 1;
            end
            if (acc == 3) valid1 = 1'b0;
            checkOutput("b2b_assert", {28'd0, assert1},
                        (phase != 0 && !cur_kind) ? (32'd1 << cur_src) : 32'd0);
            checkOutput("b2b_imm", {23'd0, imm_drive1, imm_out1},
                        (phase != 0 && cur_kind) ? {23'd0, 1'b1, cur_imm} : 32'd0);
            checkOutput("b2b_load", {28'd0, load1}, (phase == 2) ? (32'd1 << cur_dst) : 32'd0);
        end
        valid1 = 1'b0;
        checkOutput("b2b_accept_cycles", cycles, 32'd9);
        for (int c = 0; c < 3; c++) begin
            tick();
            phase = (phase == 3) ? 0 : phase + 1;
            checkOutput("b2b_tail_load", {28'd0, load1}, (phase == 2) ? (32'd1 << cur_dst) : 32'd0);
            checkOutput("b2b_tail_done", {31'd0, done1}, (phase == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("b2b_ready", {31'd0, ready1}, 32'd1);
        checkOutput("b2b_count", {24'd0, count1}, 32'd6);

        // Reset while in LOAD
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd1, 8'h00);
        tick();
        checkOutput("rl_in_load", {28'd0, load1}, 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rl_assert", {28'd0, assert1}, 32'h0);
        checkOutput("rl_load", {28'd0, load1}, 32'h0);
        checkOutput("rl_ready", {31'd0, ready1}, 32'd1);
        checkOutput("rl_done", {31'd0, done1}, 32'd0);
        checkOutput("rl_count", {24'd0, count1}, 32'd0);
        tick();
        checkOutput("rl_done_after", {31'd0, done1}, 32'd0);

        // Reset beats a command offered on the same edge
        kind = 1'b0; src = 2'd1; dst = 2'd3; valid1 = 1'b1; reset = 1'b1;
        tick();
        valid1 = 1'b0; reset = 1'b0;
        tick();
        checkOutput("rp_ready", {31'd0, ready1}, 32'd1);
        checkOutput("rp_assert", {28'd0, assert1}, 32'h0);

        // SETTLE_CYCLES=3: move 3 -> 0, done at cycle 5
        applyStimulus(1'b1, 1'b0, 2'd3, 2'd0, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            checkOutput("s3_assert", {28'd0, assert3}, 32'h8);
            checkOutput("s3_load", {28'd0, load3}, (c == 4) ? 32'h1 : 32'h0);
            checkOutput("s3_done", {31'd0, done3}, (c == 5) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("s3_ready", {31'd0, ready3}, 32'd1);
        checkOutput("s3_count", {24'd0, count3}, 32'd1);

        // Count wrap: 254 more self-moves reach 255, one more wraps to 0
        for (int n = 0; n < 254; n++) begin
            applyStimulus(1'b1, 1'b0, 2'(n), 2'(n), 8'h00);
            tick();
        end
        checkOutput("wrap_255", {24'd0, count3}, 32'd255);
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd1, 8'h00);
        checkOutput("wrap_done", {31'd0, done3}, 32'd1);
        tick();
        checkOutput("wrap_zero", {24'd0, count3}, 32'd0);
        checkOutput("wrap_dut1_idle", {24'd0, count1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/transfer_sequencer.md
TRANSFER_SEQUENCER -- requirements
Module: transfer_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning number of cycles the source drives the transfer bus before the load strobe rises; legal range 1..15.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port i_cmd_valid, input, 1, command offered.
REQ-005 SHALL have port i_cmd_kind, input, 1, where 0 = register-to-register move and 1 = immediate load.
REQ-006 SHALL have port i_cmd_src, input, 2, source register index (ignored when kind=1).
REQ-007 SHALL have port i_cmd_dst, input, 2, destination register index.
REQ-008 SHALL have port i_cmd_imm, input, 8, immediate value (ignored when kind=0).
REQ-009 SHALL have port o_cmd_ready, output, 1, accepting commands.
REQ-010 SHALL have port o_assert_transfer, output, 4, per-register transfer-bus drive enables.
REQ-011 SHALL have port o_load_transfer, output, 4, per-register load strobes; registers latch on the falling edge.
REQ-012 SHALL have port o_imm_drive, output, 1, sequencer drives o_imm onto the transfer bus.
REQ-013 SHALL have port o_imm, output, 8, immediate value held for the whole transfer.
REQ-014 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port o_move_count, output, 8, count of completed commands.

Function
REQ-016 SHALL implement states IDLE, DRIVE, LOAD, LATCH.
REQ-017 SHALL accept a command on a rising edge where i_cmd_valid=1 and o_cmd_ready=1, capturing kind/src/dst/imm into internal registers.
REQ-018 SHALL assert o_cmd_ready=1 only in IDLE, combinationally from state.
REQ-019 SHALL ignore commands, without capturing them, while o_cmd_ready=0; i_cmd_valid may be held across busy cycles.
REQ-020 SHALL, on accept with kind=0 and src!=dst, enter DRIVE with o_assert_transfer[src]=1.
REQ-021 SHALL, on accept with kind=1, enter DRIVE with o_imm_drive=1 and o_imm=captured imm.
REQ-022 SHALL remain in DRIVE for exactly SETTLE_CYCLES cycles using a 4-bit down-counter, then enter LOAD.
REQ-023 SHALL, in LOAD (1 cycle), keep the source drive and set o_load_transfer[dst]=1.
REQ-024 SHALL, in LATCH (1 cycle), drop o_load_transfer to 0 while keeping the source drive, so the register latches a stable bus; o_done=1 in this cycle; next state is IDLE.
REQ-025 SHALL, on accept with kind=0 and src==dst, go directly to LATCH with no drive or load strobes: o_done pulses, o_move_count increments, and no register is disturbed.
REQ-026 SHALL give a full-transfer latency, accept edge to o_done high, of SETTLE_CYCLES+2 cycles, and for the src==dst case 1 cycle; o_cmd_ready returns 1 the cycle after o_done.
REQ-027 SHALL keep at most one bit of o_assert_transfer high at any time, and o_imm_drive high only when o_assert_transfer=0 (bus never double-driven).
REQ-028 SHALL keep at most one bit of o_load_transfer high, and only in LOAD.
REQ-029 SHALL hold all drive, load and imm outputs at 0 in IDLE.
REQ-030 SHALL increment o_move_count by 1 in the LATCH cycle, wrapping 255 -> 0 silently.
REQ-031 SHALL never have o_done high for two consecutive cycles.

Reset
REQ-032 SHALL, while i_reset=1 at a rising edge, set state to IDLE, the settle counter to 0, o_move_count to 0, o_done, o_assert_transfer, o_load_transfer, o_imm_drive and o_imm to 0, and o_cmd_ready to 1 after the edge.
REQ-033 SHALL let reset take priority over command acceptance in the same cycle; the command is dropped.
REQ-034 SHALL, on reset asserted in LOAD, drop load and drive in the same edge; the resulting destination contents are undefined, and o_move_count does not increment.

Verification
REQ-035 SHALL verify a move: SETTLE_CYCLES=1, reset, then command kind=0 src=1 dst=2 -> assert_transfer=0010 cycles 1-3, load_transfer=0100 cycle 2 only, o_done cycle 3, ready cycle 4, count=1.
REQ-036 SHALL verify an immediate load: kind=1 dst=3 imm=0xA5 -> o_imm_drive=1 with o_imm=0xA5 cycles 1-3, load_transfer=1000 cycle 2, assert_transfer=0000 throughout.
REQ-037 SHALL verify a self-move: kind=0 src=dst=0 -> no strobes, o_done at cycle 1, count increments, ready at cycle 2.
REQ-038 SHALL verify back-to-back operation: i_cmd_valid held high with 3 commands -> each accepted only when ready, no strobe overlap between commands, count=3, bus never double-driven (checked every cycle).
REQ-039 SHALL verify reset mid-operation: reset in LOAD -> all strobes 0 next cycle, ready=1, count=0, no o_done pulse.
REQ-040 SHALL verify settle and wrap: SETTLE_CYCLES=3 -> o_done at cycle 5 after accept; run 256 commands -> count wraps to 0.
